// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
//   Bundles the EX/MEM-side inputs and the MEM-stage outputs of the MIPS
//   memory-access stage.
//   master : pipeline side (drives the EX/MEM fields, observes results)
//   slave  : mem_access_stage (consumes EX/MEM fields, drives results)
//   Inputs : valid, M control (branch/MemRead/MemWrite/jump), WB[1:0],
//            zero flag, branch target, jump target, ALU result, store data,
//            destination register.
//   Outputs: stall, PC redirect (pcSel/nextPC/flush), MEM/WB register
//            fields, sticky misalign flag.
interface mem_access_stage_if;
  logic        valid_MEM_IN;
  logic        branch_MEM_IN;
  logic        MemRead_MEM_IN;
  logic        MemWrite_MEM_IN;
  logic        jump_MEM_IN;
  logic [1:0]  WB_MEM_IN;
  logic        zf_MEM_IN;
  logic [7:0]  resAdd1_MEM_IN;
  logic [31:0] concatenador_MEM_IN;
  logic [31:0] resALU_MEM_IN;
  logic [31:0] regData2_MEM_IN;
  logic [4:0]  mux2Output_MEM_IN;

  logic        stall_MEM;
  logic        pcSel_MEM;
  logic [7:0]  nextPC_MEM;
  logic        flush_MEM;
  logic        valid_MEM;
  logic [1:0]  WB_MEM;
  logic [31:0] readData_MEM;
  logic [31:0] resALU_MEM;
  logic [4:0]  mux2Output_MEM;
  logic        misalign_MEM;

  modport master (
    output valid_MEM_IN, branch_MEM_IN, MemRead_MEM_IN, MemWrite_MEM_IN,
           jump_MEM_IN, WB_MEM_IN, zf_MEM_IN, resAdd1_MEM_IN,
           concatenador_MEM_IN, resALU_MEM_IN, regData2_MEM_IN,
           mux2Output_MEM_IN,
    input  stall_MEM, pcSel_MEM, nextPC_MEM, flush_MEM, valid_MEM, WB_MEM,
           readData_MEM, resALU_MEM, mux2Output_MEM, misalign_MEM
  );

  modport slave (
    input  valid_MEM_IN, branch_MEM_IN, MemRead_MEM_IN, MemWrite_MEM_IN,
           jump_MEM_IN, WB_MEM_IN, zf_MEM_IN, resAdd1_MEM_IN,
           concatenador_MEM_IN, resALU_MEM_IN, regData2_MEM_IN,
           mux2Output_MEM_IN,
    output stall_MEM, pcSel_MEM, nextPC_MEM, flush_MEM, valid_MEM, WB_MEM,
           readData_MEM, resALU_MEM, mux2Output_MEM, misalign_MEM
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM stage of the 5-stage MIPS pipeline: word-addressed data memory with
//   RD_LAT-cycle reads, branch/jump resolution to a next-PC select, and the
//   MEM/WB pipeline register. Multi-cycle reads stall the upstream stages.
//   Ports:
//     clk_MEM, rst_MEM : clock, synchronous active-high reset
//     bus (slave)      : EX/MEM inputs and MEM-stage outputs
//     stallCount_MEM   : saturating stall-cycle counter (only with MEM_PERF_EN)
//   Parameters: DEPTH (words), ADDR_W (word-index width), RD_LAT (1..4).
//   Optional feature macro: MEM_PERF_EN.
module mem_access_stage #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 2
) (
  input  logic                 clk_MEM,
  input  logic                 rst_MEM,
`ifdef MEM_PERF_EN
  output logic [15:0]          stallCount_MEM,
`endif
  mem_access_stage_if.slave    bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [1:0] LAST = 2'(RD_LAT - 1);

  logic [31:0]       mem [DEPTH];
  state_t            state, state_n;
  logic [1:0]        cnt, cnt_n;
  logic              stall;

  logic [ADDR_W-1:0] idx;
  logic              mis, oor, rd, wr;
  logic [31:0]       rdata;
  logic              take_j, take_b;

  logic              valid_p0;
  logic [1:0]        wb_p0;
  logic [31:0]       rdata_p0;
  logic [31:0]       alu_p0;
  logic [4:0]        dst_p0;
  logic              misalign_q;

  logic              unused_conc;
  assign unused_conc = ^bus.concatenador_MEM_IN[31:8];

  // Any word address past the array is out of range, including ones that
  // would otherwise alias back into the array through the truncated index.
  assign idx = bus.resALU_MEM_IN[ADDR_W+1:2];
  assign mis = (bus.resALU_MEM_IN[1:0] != 2'b00);
  assign oor = (bus.resALU_MEM_IN[31:2] >= 30'(DEPTH));
  assign wr  = bus.valid_MEM_IN & bus.MemWrite_MEM_IN;
  // A simultaneous MemRead/MemWrite behaves as a store, so it never stalls.
  assign rd  = bus.valid_MEM_IN & bus.MemRead_MEM_IN & ~bus.MemWrite_MEM_IN;

  assign rdata = (mis | oor) ? 32'h0 : mem[idx];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    case (state)
      IDLE: begin
        if (rd && (RD_LAT > 1)) begin
          stall   = 1'b1;
          state_n = WAIT;
          cnt_n   = 2'd1;
        end
      end
      WAIT: begin
        stall = (cnt != LAST);
        cnt_n = cnt + 2'd1;
        if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = 2'd0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk_MEM) begin
    if (rst_MEM) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Stores: single-cycle, dropped when misaligned or out of range.
  always_ff @(posedge clk_MEM) begin
    if (wr && !mis && !oor) mem[idx] <= bus.regData2_MEM_IN;
  end

  // MEM/WB register (_p0): captures on non-stalled edges, bubble otherwise.
  always_ff @(posedge clk_MEM) begin
    if (rst_MEM) begin
      valid_p0   <= 1'b0;
      wb_p0      <= 2'b00;
      rdata_p0   <= 32'h0;
      alu_p0     <= 32'h0;
      dst_p0     <= 5'd0;
      misalign_q <= 1'b0;
    end else begin
      if (!stall) begin
        valid_p0 <= bus.valid_MEM_IN;
        wb_p0    <= bus.valid_MEM_IN ? bus.WB_MEM_IN : 2'b00;
        rdata_p0 <= rdata;
        alu_p0   <= bus.resALU_MEM_IN;
        dst_p0   <= bus.mux2Output_MEM_IN;
      end else begin
        valid_p0 <= 1'b0;
        wb_p0    <= 2'b00;
      end
      if ((rd | wr) && mis && !stall) misalign_q <= 1'b1;
    end
  end

`ifdef MEM_PERF_EN
  always_ff @(posedge clk_MEM) begin
    if (rst_MEM)                               stallCount_MEM <= 16'h0;
    else if (stall && stallCount_MEM != 16'hFFFF) stallCount_MEM <= stallCount_MEM + 16'h1;
  end
`endif

  // Redirects are suppressed while the stage is frozen on a read.
  assign take_j = bus.valid_MEM_IN & bus.jump_MEM_IN;
  assign take_b = bus.valid_MEM_IN & bus.branch_MEM_IN & bus.zf_MEM_IN;

  assign bus.stall_MEM      = stall;
  assign bus.pcSel_MEM      = ~stall & (take_j | take_b);
  assign bus.flush_MEM      = ~stall & (take_j | take_b);
  assign bus.nextPC_MEM     = take_j ? bus.concatenador_MEM_IN[7:0] : bus.resAdd1_MEM_IN;
  assign bus.valid_MEM      = valid_p0;
  assign bus.WB_MEM         = wb_p0;
  assign bus.readData_MEM   = rdata_p0;
  assign bus.resALU_MEM     = alu_p0;
  assign bus.mux2Output_MEM = dst_p0;
  assign bus.misalign_MEM   = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  mem_access_stage_if ifa();
  mem_access_stage_if ifb();

`ifdef MEM_PERF_EN
  logic [15:0] sc_a, sc_b;
`endif

  mem_access_stage #(.DEPTH(64), .ADDR_W(6), .RD_LAT(2)) dut_a (
    .clk_MEM(clk), .rst_MEM(rst_a),
`ifdef MEM_PERF_EN
    .stallCount_MEM(sc_a),
`endif
    .bus(ifa));

  mem_access_stage #(.DEPTH(64), .ADDR_W(6), .RD_LAT(4)) dut_b (
    .clk_MEM(clk), .rst_MEM(rst_b),
`ifdef MEM_PERF_EN
    .stallCount_MEM(sc_b),
`endif
    .bus(ifb));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic v, br, j, zf, mr, mw;
    logic [7:0]  add1;
    logic [31:0] conc, addr, data;
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic        e_pcsel;
    logic [7:0]  e_npc;
    logic        e_valid;
    logic [1:0]  e_wb;
  } vec_t;

  vec_t vt[9];

  task automatic set_a(input logic v, br, j, zf, mr, mw, input logic [7:0] add1,
                       input logic [31:0] conc, addr, data, input logic [1:0] wb,
                       input logic [4:0] rd);
    ifa.valid_MEM_IN = v;     ifa.branch_MEM_IN = br;  ifa.jump_MEM_IN = j;
    ifa.zf_MEM_IN = zf;       ifa.MemRead_MEM_IN = mr; ifa.MemWrite_MEM_IN = mw;
    ifa.resAdd1_MEM_IN = add1; ifa.concatenador_MEM_IN = conc;
    ifa.resALU_MEM_IN = addr; ifa.regData2_MEM_IN = data;
    ifa.WB_MEM_IN = wb;       ifa.mux2Output_MEM_IN = rd;
  endtask

  task automatic set_b(input logic v, mr, mw, input logic [31:0] addr, data);
    ifb.valid_MEM_IN = v;   ifb.branch_MEM_IN = 1'b0; ifb.jump_MEM_IN = 1'b0;
    ifb.zf_MEM_IN = 1'b0;   ifb.MemRead_MEM_IN = mr;  ifb.MemWrite_MEM_IN = mw;
    ifb.resAdd1_MEM_IN = 8'h0; ifb.concatenador_MEM_IN = 32'h0;
    ifb.resALU_MEM_IN = addr;  ifb.regData2_MEM_IN = data;
    ifb.WB_MEM_IN = 2'b11;  ifb.mux2Output_MEM_IN = 5'd2;
  endtask

  // Two-cycle load on the RD_LAT=2 instance.
  task automatic read_a(input string name, input logic [31:0] addr,
                        input logic [4:0] rd, input logic [31:0] exp_data);
    @(negedge clk);
    set_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 32'h0, addr, 32'h0, 2'b11, rd);
    #1 chk({name, "_stall"}, 32'(ifa.stall_MEM), 32'h1);
    @(posedge clk); #1;
    chk({name, "_bubble_valid"}, 32'(ifa.valid_MEM), 32'h0);
    chk({name, "_bubble_wb"}, 32'(ifa.WB_MEM), 32'h0);
    chk({name, "_release"}, 32'(ifa.stall_MEM), 32'h0);
    @(posedge clk); #1;
    chk({name, "_valid"}, 32'(ifa.valid_MEM), 32'h1);
    chk({name, "_wb"}, 32'(ifa.WB_MEM), 32'h3);
    chk({name, "_data"}, ifa.readData_MEM, exp_data);
    chk({name, "_dst"}, 32'(ifa.mux2Output_MEM), 32'(rd));
    @(negedge clk);
    set_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0);
  endtask

  // Load on the RD_LAT=4 instance; returns the number of stalled cycles.
  task automatic read_b(input logic [31:0] addr, output int n);
    @(negedge clk);
    set_b(1'b1, 1'b1, 1'b0, addr, 32'h0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (!ifb.stall_MEM) break;
      n++;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    //        v     br    j     zf    mr    mw    add1   conc          addr          data          wb     rd    pcsel npc    valid ewb
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0,        32'h10,       32'hDEADBEEF, 2'b00, 5'd0, 1'b0, 8'h00, 1'b1, 2'b00};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0,        32'h00,       32'hAAAA5555, 2'b00, 5'd0, 1'b0, 8'h00, 1'b1, 2'b00};
    vt[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 32'h0,        32'h20,       32'h12345678, 2'b00, 5'd0, 1'b0, 8'h00, 1'b1, 2'b00};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h2C, 32'h0,        32'h04,       32'h0,        2'b00, 5'd0, 1'b1, 8'h2C, 1'b1, 2'b00};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h2C, 32'h0,        32'h08,       32'h0,        2'b00, 5'd0, 1'b0, 8'h00, 1'b1, 2'b00};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h2C, 32'h40,       32'h0C,       32'h0,        2'b00, 5'd0, 1'b1, 8'h40, 1'b1, 2'b00};
    vt[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h2C, 32'hFFFFFF80, 32'h18,       32'h0,        2'b00, 5'd0, 1'b1, 8'h80, 1'b1, 2'b00};
    vt[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h2C, 32'h40,       32'h1C,       32'h0,        2'b11, 5'd9, 1'b0, 8'h00, 1'b0, 2'b00};
    vt[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        32'h1234,     32'h0,        2'b10, 5'd3, 1'b0, 8'h00, 1'b1, 2'b10};

    set_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0);
    set_b(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("rst_valid", 32'(ifa.valid_MEM), 32'h0);
    chk("rst_wb", 32'(ifa.WB_MEM), 32'h0);
    chk("rst_rdata", ifa.readData_MEM, 32'h0);
    chk("rst_alu", ifa.resALU_MEM, 32'h0);
    chk("rst_dst", 32'(ifa.mux2Output_MEM), 32'h0);
    chk("rst_misalign", 32'(ifa.misalign_MEM), 32'h0);
    chk("rst_stall", 32'(ifa.stall_MEM), 32'h0);
    chk("rst_pcsel", 32'(ifa.pcSel_MEM), 32'h0);
    chk("rst_flush", 32'(ifa.flush_MEM), 32'h0);
`ifdef MEM_PERF_EN
    chk("rst_stallcount", 32'(sc_a), 32'h0);
`endif

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      set_a(vt[i].v, vt[i].br, vt[i].j, vt[i].zf, vt[i].mr, vt[i].mw, vt[i].add1,
            vt[i].conc, vt[i].addr, vt[i].data, vt[i].wb, vt[i].rd);
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(ifa.stall_MEM), 32'h0);
      chk($sformatf("vec%0d_pcsel", i), 32'(ifa.pcSel_MEM), 32'(vt[i].e_pcsel));
      chk($sformatf("vec%0d_flush", i), 32'(ifa.flush_MEM), 32'(vt[i].e_pcsel));
      if (vt[i].e_pcsel)
        chk($sformatf("vec%0d_nextpc", i), 32'(ifa.nextPC_MEM), 32'(vt[i].e_npc));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 32'(ifa.valid_MEM), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d_wb", i), 32'(ifa.WB_MEM), 32'(vt[i].e_wb));
      chk($sformatf("vec%0d_alu", i), ifa.resALU_MEM, vt[i].addr);
      chk($sformatf("vec%0d_dst", i), 32'(ifa.mux2Output_MEM), 32'(vt[i].rd));
    end

    read_a("lw_10", 32'h10, 5'd7, 32'hDEADBEEF);
    read_a("lw_20", 32'h20, 5'd12, 32'h12345678);
    read_a("lw_00", 32'h00, 5'd1, 32'hAAAA5555);

    chk("misalign_before", 32'(ifa.misalign_MEM), 32'h0);
    @(negedge clk);
    set_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0, 32'h0, 32'h13, 32'hFFFFFFFF, 2'b00, 5'd0);
    #1 chk("sw_mis_stall", 32'(ifa.stall_MEM), 32'h0);
    @(posedge clk); #1;
    chk("misalign_set", 32'(ifa.misalign_MEM), 32'h1);
    @(negedge clk);
    set_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0);
    repeat (3) @(posedge clk);
    #1 chk("misalign_sticky", 32'(ifa.misalign_MEM), 32'h1);
    read_a("lw_after_mis", 32'h10, 5'd7, 32'hDEADBEEF);
    read_a("lw_oor", 32'h100, 5'd5, 32'h0);
`ifdef MEM_PERF_EN
    chk("stallcount_a", 32'(sc_a), 32'd5);
`endif

    // RD_LAT=4 instance: full read, then reset during the wait.
    @(negedge clk);
    set_b(1'b1, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D);
    @(negedge clk);
    set_b(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    read_b(32'h8, n);
    chk("b_stall_cycles", 32'(n), 32'd3);
    chk("b_valid", 32'(ifb.valid_MEM), 32'h1);
    chk("b_data", ifb.readData_MEM, 32'hCAFEF00D);
    @(negedge clk);
    set_b(1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
    #1 chk("b_wait_stall1", 32'(ifb.stall_MEM), 32'h1);
    @(negedge clk);
    #1 chk("b_wait_stall2", 32'(ifb.stall_MEM), 32'h1);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    set_b(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("b_rst_stall", 32'(ifb.stall_MEM), 32'h0);
    chk("b_rst_valid", 32'(ifb.valid_MEM), 32'h0);
    chk("b_rst_wb", 32'(ifb.WB_MEM), 32'h0);
`ifdef MEM_PERF_EN
    chk("b_rst_stallcount", 32'(sc_b), 32'h0);
`endif
    read_b(32'h8, n);
    chk("b_after_rst_cycles", 32'(n), 32'd3);
    chk("b_after_rst_data", ifb.readData_MEM, 32'hCAFEF00D);
`ifdef MEM_PERF_EN
    chk("b_stallcount", 32'(sc_b), 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
